// File: rtl/fetch_sequencer.sv
// Fetch/retire sequencer: owns the architectural PC, Z/C/N flags and link register,
// fetching each instruction over a req/valid handshake and holding it until execute retires it.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_data,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic [31:0] next_pc,
    input  logic        flags_we,
    input  logic        alu_zero,
    input  logic        alu_carry,
    input  logic        alu_negative,
    input  logic        link_we,
    input  logic        halt_req,
    output logic [31:0] pc,
    output logic        zero,
    output logic        carry,
    output logic        negative,
    output logic [31:0] link,
    output logic [31:0] retired,
    output logic        halted,
    output logic        fault
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_d;
    logic [31:0]      pc_d, instr_d, link_d, retired_d;
    logic             zero_d, carry_d, negative_d, halted_d, fault_d;
    logic             imem_req_d, instr_valid_d;

    // The PC register drives the fetch address directly.
    assign imem_addr = pc;

    // Next-state and next-value logic.
    always_comb begin
        next_state    = state;
        wait_cnt_d    = wait_cnt;
        pc_d          = pc;
        instr_d       = instr;
        link_d        = link;
        retired_d     = retired;
        zero_d        = zero;
        carry_d       = carry;
        negative_d    = negative;
        halted_d      = halted;
        fault_d       = fault;
        imem_req_d    = 1'b0;
        instr_valid_d = 1'b0;

        case (state)
            ST_REQ: begin
                // A valid on the last allowed cycle still beats the timeout.
                if (imem_valid) begin
                    instr_d    = imem_data;
                    wait_cnt_d = '0;
                    next_state = ST_ISSUE;
                end else if (wait_cnt == CNT_LAST) begin
                    fault_d    = 1'b1;
                    halted_d   = 1'b1;
                    next_state = ST_HALT;
                end else begin
                    wait_cnt_d = wait_cnt + CNT_W'(1);
                end
            end
            ST_ISSUE: begin
                if (exec_done) begin
                    pc_d      = {next_pc[31:2], 2'b00};
                    retired_d = retired + 32'd1;
                    if (flags_we) begin
                        zero_d     = alu_zero;
                        carry_d    = alu_carry;
                        negative_d = alu_negative;
                    end
                    if (link_we) begin
                        link_d = pc + 32'd4;
                    end
                    if (halt_req) begin
                        halted_d   = 1'b1;
                        next_state = ST_HALT;
                    end else begin
                        next_state = ST_REQ;
                    end
                end
            end
            ST_HALT: begin
                next_state = ST_HALT;
            end
            default: begin
                next_state = ST_REQ;
            end
        endcase

        // Handshake outputs are registered from the state being entered.
        imem_req_d    = (next_state == ST_REQ);
        instr_valid_d = (next_state == ST_ISSUE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_REQ;
            wait_cnt    <= '0;
            pc          <= RESET_PC;
            instr       <= '0;
            link        <= '0;
            retired     <= '0;
            zero        <= 1'b0;
            carry       <= 1'b0;
            negative    <= 1'b0;
            halted      <= 1'b0;
            fault       <= 1'b0;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
        end else begin
            state       <= next_state;
            wait_cnt    <= wait_cnt_d;
            pc          <= pc_d;
            instr       <= instr_d;
            link        <= link_d;
            retired     <= retired_d;
            zero        <= zero_d;
            carry       <= carry_d;
            negative    <= negative_d;
            halted      <= halted_d;
            fault       <= fault_d;
            imem_req    <= imem_req_d;
            instr_valid <= instr_valid_d;
        end
    end

endmodule
